// File: rtl/pipelined_control_if.sv
// Control-unit bus between the MIPS ID stage and the datapath.
// fwd_a/fwd_b are present only when FORWARD_EN is defined.
interface pipelined_control_if #(
    parameter int REG_AW = 5,
    parameter int ALU_CW = 2,
    parameter int CNT_W  = 16
);
    logic [31:0]       instruction;
    logic              ex_branch_taken;
    logic              stall;
    logic              flush_ifid;
    logic              id_jump;
    logic              ex_alusrc;
    logic              ex_regdest;
    logic              ex_branch;
    logic              ex_jr;
    logic [ALU_CW-1:0] ex_aluctrl;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic              mem_memwrite;
    logic              mem_memtoreg;
    logic              wb_regwrite;
    logic              wb_memtoreg;
    logic [REG_AW-1:0] wb_dest;
    logic [CNT_W-1:0]  stall_count;
`ifdef FORWARD_EN
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
`endif

    modport slave (
        input  instruction, ex_branch_taken,
        output stall, flush_ifid, id_jump, ex_alusrc, ex_regdest, ex_branch, ex_jr,
               ex_aluctrl, ex_rs, ex_rt, mem_memwrite, mem_memtoreg, wb_regwrite,
               wb_memtoreg, wb_dest, stall_count
`ifdef FORWARD_EN
        , output fwd_a, fwd_b
`endif
    );

    modport master (
        output instruction, ex_branch_taken,
        input  stall, flush_ifid, id_jump, ex_alusrc, ex_regdest, ex_branch, ex_jr,
               ex_aluctrl, ex_rs, ex_rt, mem_memwrite, mem_memtoreg, wb_regwrite,
               wb_memtoreg, wb_dest, stall_count
`ifdef FORWARD_EN
        , input fwd_a, fwd_b
`endif
    );
endinterface

// File: rtl/pipelined_control.sv
// 5-stage MIPS control unit: ID decode, ID/EX-EX/MEM-MEM/WB control pipe, hazard stall/flush.
// Define FORWARD_EN to add EX/MEM and MEM/WB forwarding selects and stall on load-use only.
module pipelined_control #(
    parameter int REG_AW = 5,
    parameter int ALU_CW = 2,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    pipelined_control_if.slave bus
);

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_NOR    = 6'b100111;
    localparam logic [5:0] FN_SLTU   = 6'b101011;

    typedef struct packed {
        logic              alusrc;
        logic              regdest;
        logic              branch;
        logic              jr;
        logic [ALU_CW-1:0] aluctrl;
        logic              memwrite;
        logic              memtoreg;
        logic              regwrite;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] dest;
    } idex_t;

    typedef struct packed {
        logic              memwrite;
        logic              memtoreg;
        logic              regwrite;
        logic [REG_AW-1:0] dest;
    } exmem_t;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] dest;
    } memwb_t;

    // Source tags of unused operands are zeroed at decode, so a nonzero dest can only hit a real use.
    function automatic logic src_hit(input logic [REG_AW-1:0] dest,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt);
        return (dest != '0) && ((dest == rs) || (dest == rt));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

`ifdef FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                           input logic [REG_AW-1:0] mem_dest,
                                           input logic [REG_AW-1:0] wb_dest);
        if (src != '0 && mem_dest == src) return 2'b10;
        if (src != '0 && wb_dest == src)  return 2'b01;
        return 2'b00;
    endfunction
`endif

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs_f;
    logic [REG_AW-1:0] rt_f;
    logic [REG_AW-1:0] rd_f;
    logic              shamt_unused;

    assign op           = bus.instruction[31:26];
    assign funct        = bus.instruction[5:0];
    assign rs_f         = REG_AW'(bus.instruction[25:21]);
    assign rt_f         = REG_AW'(bus.instruction[20:16]);
    assign rd_f         = REG_AW'(bus.instruction[15:11]);
    assign shamt_unused = ^bus.instruction[10:6];

    idex_t            dec;
    logic             jump;
    logic             use_rs;
    logic             use_rt;
    logic             hazard;
    logic             stall;
    idex_t            idex_d, idex_q;
    exmem_t           exmem_d, exmem_q;
    memwb_t           memwb_d, memwb_q;
    logic [CNT_W-1:0] stall_count_d, stall_count_q;

    // ---- ID: decode; anything outside the table stays an all-zero bubble
    always_comb begin
        dec    = '0;
        jump   = 1'b0;
        use_rs = 1'b0;
        use_rt = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SUBU, FN_NOR, FN_SLTU: begin
                        dec.regdest  = 1'b1;
                        dec.regwrite = 1'b1;
                        use_rs       = 1'b1;
                        use_rt       = 1'b1;
                        if (funct == FN_SUBU)     dec.aluctrl = ALU_CW'(1);
                        else if (funct == FN_NOR) dec.aluctrl = ALU_CW'(2);
                        else                      dec.aluctrl = ALU_CW'(3);
                    end
                    FN_JR: begin
                        dec.jr = 1'b1;
                        use_rs = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                dec.branch  = 1'b1;
                dec.aluctrl = ALU_CW'(1);
                use_rs      = 1'b1;
            end
            OP_J: jump = 1'b1;
            OP_ADDI, OP_LW: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = (op == OP_LW);
                use_rs       = 1'b1;
            end
            OP_SW: begin
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            default: ;
        endcase
        dec.rs = use_rs ? rs_f : '0;
        dec.rt = use_rt ? rt_f : '0;
        if (dec.regwrite) dec.dest = dec.regdest ? rd_f : rt_f;
    end

    // ---- ID: hazard detection; a flush this cycle squashes the stall
    always_comb begin
`ifdef FORWARD_EN
        hazard = idex_q.memtoreg && src_hit(idex_q.dest, dec.rs, dec.rt);
`else
        hazard = src_hit(idex_q.dest, dec.rs, dec.rt) || src_hit(exmem_q.dest, dec.rs, dec.rt);
`endif
        stall = hazard && !(bus.ex_branch_taken || jump);
    end

    // ---- ID/EX, EX/MEM, MEM/WB next state
    always_comb begin
        idex_d           = (stall || bus.ex_branch_taken) ? '0 : dec;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.memtoreg = idex_q.memtoreg;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.dest     = idex_q.dest;
        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.memtoreg = exmem_q.memtoreg;
        memwb_d.dest     = exmem_q.dest;
        stall_count_d    = stall ? sat_inc(stall_count_q) : stall_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idex_q        <= '0;
            exmem_q       <= '0;
            memwb_q       <= '0;
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            exmem_q       <= exmem_d;
            memwb_q       <= memwb_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Combinational outputs are gated so every output reads 0 while reset is held.
    assign bus.stall        = stall;
    assign bus.flush_ifid   = (bus.ex_branch_taken || jump) && !reset;
    assign bus.id_jump      = jump && !reset;
    assign bus.ex_alusrc    = idex_q.alusrc;
    assign bus.ex_regdest   = idex_q.regdest;
    assign bus.ex_branch    = idex_q.branch;
    assign bus.ex_jr        = idex_q.jr;
    assign bus.ex_aluctrl   = idex_q.aluctrl;
    assign bus.ex_rs        = idex_q.rs;
    assign bus.ex_rt        = idex_q.rt;
    assign bus.mem_memwrite = exmem_q.memwrite;
    assign bus.mem_memtoreg = exmem_q.memtoreg;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;
    assign bus.wb_dest      = memwb_q.dest;
    assign bus.stall_count  = stall_count_q;
`ifdef FORWARD_EN
    assign bus.fwd_a        = fwd_sel(idex_q.rs, exmem_q.dest, memwb_q.dest);
    assign bus.fwd_b        = fwd_sel(idex_q.rt, exmem_q.dest, memwb_q.dest);
`endif

endmodule

// File: tb/tb_pipelined_control.sv
// Scoreboard bench for pipelined_control: expectations are queued with the cycle they are due.
module tb_pipelined_control;

    localparam int REG_AW = 5;
    localparam int ALU_CW = 2;
    localparam int CNT_W  = 4;
`ifdef FORWARD_EN
    localparam int LU_ST  = 1;
    localparam int RAW_ST = 0;
`else
    localparam int LU_ST  = 2;
    localparam int RAW_ST = 2;
`endif

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] FN_JR     = 6'b001000;
    localparam logic [5:0] FN_SUBU   = 6'b100011;
    localparam logic [5:0] FN_NOR    = 6'b100111;
    localparam logic [5:0] FN_SLTU   = 6'b101011;
    localparam logic [5:0] FN_ADD    = 6'b100000;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pipelined_control_if #(.REG_AW(REG_AW), .ALU_CW(ALU_CW), .CNT_W(CNT_W)) bus ();
    pipelined_control #(.REG_AW(REG_AW), .ALU_CW(ALU_CW), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int    cyc;
        string tag;
        int    exp;
    } sb_t;

    sb_t sb_q[$];
    int  cyc      = 0;
    int  base     = 0;
    int  n_checks = 0;
    int  n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] i_lw, i_subu, i_addi, i_nor, i_j, i_nop;

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d (test cycle %0d)", tag, obs, exp, cyc - base);
        end
    endtask

    function automatic int probe(input string tag);
        case (tag)
            "stall":        return int'(bus.stall);
            "flush":        return int'(bus.flush_ifid);
            "id_jump":      return int'(bus.id_jump);
            "ex_alusrc":    return int'(bus.ex_alusrc);
            "ex_regdest":   return int'(bus.ex_regdest);
            "ex_branch":    return int'(bus.ex_branch);
            "ex_jr":        return int'(bus.ex_jr);
            "ex_aluctrl":   return int'(bus.ex_aluctrl);
            "ex_rs":        return int'(bus.ex_rs);
            "ex_rt":        return int'(bus.ex_rt);
            "mem_memwrite": return int'(bus.mem_memwrite);
            "mem_memtoreg": return int'(bus.mem_memtoreg);
            "wb_regwrite":  return int'(bus.wb_regwrite);
            "wb_memtoreg":  return int'(bus.wb_memtoreg);
            "wb_dest":      return int'(bus.wb_dest);
            "stall_count":  return int'(bus.stall_count);
`ifdef FORWARD_EN
            "fwd_a":        return int'(bus.fwd_a);
            "fwd_b":        return int'(bus.fwd_b);
`endif
            default:        return -1;
        endcase
    endfunction

    task automatic sb_push(input int k, input string tag, input int exp);
        sb_t e;
        e.cyc = base + k;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic push_zero(input int k);
        sb_push(k, "stall", 0);        sb_push(k, "flush", 0);
        sb_push(k, "id_jump", 0);      sb_push(k, "ex_alusrc", 0);
        sb_push(k, "ex_regdest", 0);   sb_push(k, "ex_branch", 0);
        sb_push(k, "ex_jr", 0);        sb_push(k, "ex_aluctrl", 0);
        sb_push(k, "ex_rs", 0);        sb_push(k, "ex_rt", 0);
        sb_push(k, "mem_memwrite", 0); sb_push(k, "mem_memtoreg", 0);
        sb_push(k, "wb_regwrite", 0);  sb_push(k, "wb_memtoreg", 0);
        sb_push(k, "wb_dest", 0);      sb_push(k, "stall_count", 0);
`ifdef FORWARD_EN
        sb_push(k, "fwd_a", 0);        sb_push(k, "fwd_b", 0);
`endif
    endtask

    task automatic sb_drain();
        sb_t rest[$];
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc == cyc) check_val(sb_q[i].tag, probe(sb_q[i].tag), sb_q[i].exp);
            else rest.push_back(sb_q[i]);
        end
        sb_q = rest;
    endtask

    task automatic run_cycle(input logic [31:0] instr, input logic br);
        bus.instruction     = instr;
        bus.ex_branch_taken = br;
        #2;
        sb_drain();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.instruction     = '0;
        bus.ex_branch_taken = 1'b0;
        reset               = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        base  = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ins;
        int          k;
        i_lw   = enc_i(OP_LW, 5'd1, 5'd3, 16'd0);
        i_subu = enc_r(FN_SUBU, 5'd3, 5'd5, 5'd4);
        i_addi = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd5);
        i_nor  = enc_r(FN_NOR, 5'd2, 5'd7, 5'd6);
        i_j    = {OP_J, 26'd64};
        i_nop  = '0;
        bus.instruction     = '0;
        bus.ex_branch_taken = 1'b0;

        // Reset state, then an asynchronous reset mid-cycle with an LW in EX
        do_reset();
        push_zero(0);
        sb_push(1, "stall", 1);
        for (int c = 0; c <= LU_ST + 2; c++)
            run_cycle((c == 0 || c == LU_ST + 2) ? i_lw : i_subu, 1'b0);
        k = LU_ST + 3;
        sb_push(k, "ex_alusrc", 1);
        sb_push(k, "stall_count", LU_ST);
        sb_push(k, "id_jump", 1);
        sb_push(k, "flush", 1);
        bus.instruction     = i_j;
        bus.ex_branch_taken = 1'b1;
        #2;
        sb_drain();
        reset = 1'b1;
        #1;
        push_zero(k);
        sb_drain();
        @(posedge clk);
        #1;

        // Latency: ADDI $2,$0,5 followed by NOPs
        do_reset();
        for (int c = 0; c <= 4; c++) begin
            ins = (c == 0) ? i_addi : i_nop;
            if (c == 0) begin
                sb_push(0, "stall", 0);
                sb_push(1, "ex_alusrc", 1);
                sb_push(1, "ex_aluctrl", 0);
                sb_push(1, "ex_regdest", 0);
                sb_push(2, "ex_alusrc", 0);
                sb_push(3, "wb_regwrite", 1);
                sb_push(3, "wb_dest", 2);
                sb_push(3, "wb_memtoreg", 0);
                sb_push(4, "wb_regwrite", 0);
            end
            sb_push(c, "mem_memwrite", 0);
            run_cycle(ins, 1'b0);
        end

        // Load-use: LW $3,0($1) then SUBU $4,$3,$5 held while stalled
        do_reset();
        for (int c = 0; c <= LU_ST + 4; c++) begin
            ins = (c == 0) ? i_lw : (c <= LU_ST + 1) ? i_subu : i_nop;
            if (c == 0) begin
                sb_push(0, "stall", 0);
                sb_push(1, "stall_count", 0);
                sb_push(2, "mem_memtoreg", 1);
                sb_push(3, "wb_memtoreg", 1);
                sb_push(3, "wb_regwrite", 1);
                sb_push(3, "wb_dest", 3);
            end
            if (c >= 1 && c <= LU_ST) sb_push(c, "stall", 1);
            if (c == 2) begin
                sb_push(2, "ex_alusrc", 0);
                sb_push(2, "ex_aluctrl", 0);
            end
            if (c == LU_ST + 1) begin
                sb_push(c, "stall", 0);
                sb_push(c, "stall_count", LU_ST);
                sb_push(c + 1, "ex_aluctrl", 1);
                sb_push(c + 1, "ex_regdest", 1);
                sb_push(c + 1, "ex_rs", 3);
                sb_push(c + 1, "ex_rt", 5);
`ifdef FORWARD_EN
                sb_push(c + 1, "fwd_a", 1);
                sb_push(c + 1, "fwd_b", 0);
`endif
                sb_push(c + 3, "wb_dest", 4);
                sb_push(c + 3, "wb_memtoreg", 0);
            end
            run_cycle(ins, 1'b0);
        end

        // RAW: ADDI $2 then NOR $6,$2,$7
        do_reset();
        for (int c = 0; c <= RAW_ST + 4; c++) begin
            ins = (c == 0) ? i_addi : (c <= RAW_ST + 1) ? i_nor : i_nop;
            if (c >= 1 && c <= RAW_ST) sb_push(c, "stall", 1);
            if (c == RAW_ST + 1) begin
                sb_push(c, "stall", 0);
                sb_push(c, "stall_count", RAW_ST);
                sb_push(c + 1, "ex_aluctrl", 2);
                sb_push(c + 1, "ex_rs", 2);
                sb_push(c + 1, "ex_rt", 7);
                sb_push(c + 1, "stall_count", RAW_ST);
`ifdef FORWARD_EN
                sb_push(c + 1, "fwd_a", 2);
                sb_push(c + 1, "fwd_b", 0);
`endif
                sb_push(c + 3, "wb_dest", 6);
                sb_push(c + 3, "wb_regwrite", 1);
            end
            run_cycle(ins, 1'b0);
        end

        // Flush priority over a load-use hazard, then J
        do_reset();
        sb_push(1, "stall", 0);        sb_push(1, "flush", 1);
        sb_push(1, "ex_alusrc", 1);
        sb_push(2, "ex_aluctrl", 0);   sb_push(2, "ex_rs", 0);
        sb_push(2, "ex_rt", 0);        sb_push(2, "ex_regdest", 0);
        sb_push(2, "stall", 0);        sb_push(2, "flush", 0);
        sb_push(2, "stall_count", 0);
        sb_push(3, "id_jump", 1);      sb_push(3, "flush", 1);
        sb_push(3, "stall", 0);        sb_push(3, "wb_dest", 3);
        sb_push(4, "ex_alusrc", 0);    sb_push(4, "ex_jr", 0);
        sb_push(4, "ex_rs", 0);        sb_push(4, "id_jump", 0);
        sb_push(4, "flush", 0);        sb_push(4, "wb_regwrite", 0);
        sb_push(4, "wb_dest", 0);
        run_cycle(i_lw, 1'b0);
        run_cycle(i_subu, 1'b1);
        run_cycle(i_nop, 1'b0);
        run_cycle(i_j, 1'b0);
        run_cycle(i_nop, 1'b0);
        run_cycle(i_nop, 1'b0);

        // Decode table: illegal op, JR, BLTZ, SW, SLTU, unsupported funct
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            case (c)
                0: begin
                    ins = {6'b111010, 5'd1, 5'd2, 16'hFFFF};
                    sb_push(0, "id_jump", 0);
                    sb_push(1, "ex_alusrc", 0);  sb_push(1, "ex_regdest", 0);
                    sb_push(1, "ex_aluctrl", 0); sb_push(1, "ex_rs", 0);
                    sb_push(2, "mem_memwrite", 0);
                    sb_push(3, "wb_regwrite", 0); sb_push(3, "wb_dest", 0);
                end
                1: begin
                    ins = enc_r(FN_JR, 5'd31, 5'd0, 5'd0);
                    sb_push(2, "ex_jr", 1); sb_push(2, "ex_rs", 31); sb_push(2, "ex_aluctrl", 0);
                end
                2: begin
                    ins = enc_i(OP_REGIMM, 5'd4, 5'd0, 16'h0010);
                    sb_push(3, "ex_branch", 1); sb_push(3, "ex_aluctrl", 1);
                    sb_push(3, "ex_rs", 4);     sb_push(3, "ex_rt", 0);
                end
                3: begin
                    ins = enc_i(OP_SW, 5'd6, 5'd5, 16'd4);
                    sb_push(4, "ex_alusrc", 1); sb_push(4, "ex_rs", 6); sb_push(4, "ex_rt", 5);
                    sb_push(5, "mem_memwrite", 1);
                    sb_push(6, "wb_regwrite", 0);
                end
                4: begin
                    ins = enc_r(FN_SLTU, 5'd10, 5'd11, 5'd9);
                    sb_push(5, "ex_aluctrl", 3); sb_push(5, "ex_regdest", 1);
                    sb_push(7, "wb_regwrite", 1); sb_push(7, "wb_dest", 9);
                end
                5: begin
                    ins = enc_r(FN_ADD, 5'd1, 5'd2, 5'd3);
                    sb_push(6, "ex_regdest", 0); sb_push(6, "ex_aluctrl", 0);
                    sb_push(8, "wb_regwrite", 0);
                end
                default: ins = i_nop;
            endcase
            run_cycle(ins, 1'b0);
        end

        // Saturation: 20 load-use pairs into a 4-bit counter
        do_reset();
        for (int p = 0; p < 20; p++) begin
            int off;
            int tot;
            off = p * (LU_ST + 2);
            tot = (p + 1) * LU_ST;
            sb_push(off, "stall", 0);
            run_cycle(i_lw, 1'b0);
            for (int s = 1; s <= LU_ST + 1; s++) begin
                if (s <= LU_ST) sb_push(off + s, "stall", 1);
                else begin
                    sb_push(off + s, "stall", 0);
                    sb_push(off + s, "stall_count", (tot > 15) ? 15 : tot);
                end
                run_cycle(i_subu, 1'b0);
            end
        end
        sb_push(20 * (LU_ST + 2) + 1, "stall_count", 15);
        run_cycle(i_nop, 1'b0);
        run_cycle(i_nop, 1'b0);

        check_val("sb_pending", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
